// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares the single-port data RAM between the control unit (port 0) and a
//   secondary requester (port 1, debug/DMA loader). At most one access is
//   granted per cycle. Port 0 has fixed priority. A saturating starvation
//   counter promotes port 1 once it has been denied STARVE_LIMIT cycles in a
//   row. Granted commands are registered onto the RAM bus. Read data returns
//   to the owning port three cycles after the grant.
//
// Ports
//   clk                  single clock, all state on posedge
//   reset                asynchronous, active-low reset
//   enable               arbitration enable (low blocks new grants only)
//   pX_req/we/addr/wdata requester command, held stable until granted
//   pX_gnt               combinational accept for this cycle
//   pX_rdata/pX_rvalid   registered read data and its one-cycle valid pulse
//   ram_en/we/addr/wdata registered RAM command bus
//   ram_rdata            synchronous RAM read data, valid the cycle after ram_en
module ram_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [7:0] LP_LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]        r_starve_cnt;
  logic              r_tag_vld_p1;
  logic              r_tag_port_p1;
  logic              r_tag_vld_p2;
  logic              r_tag_port_p2;

  logic              w_arb_ok;
  logic              w_p1_pri;
  logic              w_any_gnt;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Grant decision (combinational, cycle N). Holding reset low also forces
  // the grants off so no command can be accepted while state is cleared.
  assign w_arb_ok  = enable & reset;
  assign w_p1_pri  = p1_req & (r_starve_cnt >= LP_LIMIT);
  assign p1_gnt    = w_arb_ok & p1_req & (w_p1_pri | ~p0_req);
  assign p0_gnt    = w_arb_ok & p0_req & ~w_p1_pri;
  assign w_any_gnt = p0_gnt | p1_gnt;

  assign w_sel_we    = p1_gnt ? p1_we    : p0_we;
  assign w_sel_addr  = p1_gnt ? p1_addr  : p0_addr;
  assign w_sel_wdata = p1_gnt ? p1_wdata : p0_wdata;

  // Starvation counter: counts every cycle port 1 waits, including cycles
  // where enable is low, so the promotion is already armed when it returns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= 8'd0;
    end else if (!p1_req || p1_gnt) begin
      r_starve_cnt <= 8'd0;
    end else if (r_starve_cnt != 8'hFF) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end

  // Command stage (cycle N+1). Address and write data hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (w_any_gnt) begin
      ram_en    <= 1'b1;
      ram_we    <= w_sel_we;
      ram_addr  <= w_sel_addr;
      ram_wdata <= w_sel_wdata;
    end else begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
    end
  end

  // Read tag pipeline: stage p1 lines up with the RAM command, stage p2 with
  // the RAM output. Only reads carry a valid tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag_vld_p1  <= 1'b0;
      r_tag_port_p1 <= 1'b0;
      r_tag_vld_p2  <= 1'b0;
      r_tag_port_p2 <= 1'b0;
    end else begin
      r_tag_vld_p1  <= w_any_gnt & ~w_sel_we;
      r_tag_port_p1 <= p1_gnt;
      r_tag_vld_p2  <= r_tag_vld_p1;
      r_tag_port_p2 <= r_tag_port_p1;
    end
  end

  // Return stage (cycle N+3): capture RAM data into the owning port only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
    end else begin
      p0_rvalid <= r_tag_vld_p2 & ~r_tag_port_p2;
      p1_rvalid <= r_tag_vld_p2 &  r_tag_port_p2;
      if (r_tag_vld_p2 && !r_tag_port_p2) p0_rdata <= ram_rdata;
      if (r_tag_vld_p2 &&  r_tag_port_p2) p1_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed bench for ram_arbiter with a behavioural write-first synchronous
//   RAM attached to the command bus. Inputs change 1 ns after the rising edge,
//   outputs are sampled on the falling edge.
module tb_ram_arbiter;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       p0_req, p0_we, p1_req, p1_we;
  logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic       p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [7:0] p0_rdata, p1_rdata;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  logic       tb_ld;
  logic [7:0] tb_ld_addr, tb_ld_data;
  logic [7:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first synchronous RAM; tb_ld is a back door used for preloading.
  always @(posedge clk) begin
    if (tb_ld) begin
      mem[tb_ld_addr] <= tb_ld_data;
    end else if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        ram_rdata     <= ram_wdata;
      end else begin
        ram_rdata     <= mem[ram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    tb_ld = 1'b1; tb_ld_addr = a; tb_ld_data = d;
    step();
    tb_ld = 1'b0;
  endtask

  task automatic idle_ports();
    p0_req = 1'b0; p0_we = 1'b0; p1_req = 1'b0; p1_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    reset = 1'b0; enable = 1'b1; tb_ld = 1'b0;
    tb_ld_addr = 8'h00; tb_ld_data = 8'h00; ram_rdata = 8'h00;
    idle_ports();
    p0_addr = 8'h00; p0_wdata = 8'h00; p1_addr = 8'h00; p1_wdata = 8'h00;

    // Preload RAM while the arbiter is held in reset.
    load(8'h12, 8'hA5);
    load(8'h01, 8'h11);
    load(8'h02, 8'h22);
    load(8'h03, 8'h33);
    load(8'h05, 8'h5A);
    load(8'h06, 8'h66);

    // Reset state, with requests pending to prove gnt is forced low.
    p0_req = 1'b1; p1_req = 1'b1;
    mid();
    check("rst_p0_gnt", 32'(p0_gnt), 32'd0);
    check("rst_p1_gnt", 32'(p1_gnt), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_rdata", 32'({p0_rdata, p1_rdata}), 32'd0);
    check("rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);
    step();
    idle_ports();
    reset = 1'b1;
    step();

    // Single read: p0 reads 0x12.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h12;
    mid();
    check("rd_p0_gnt", 32'(p0_gnt), 32'd1);
    check("rd_p1_gnt", 32'(p1_gnt), 32'd0);
    step();
    p0_req = 1'b0;
    mid();
    check("rd_c1_ram_en", 32'(ram_en), 32'd1);
    check("rd_c1_ram_we", 32'(ram_we), 32'd0);
    check("rd_c1_ram_addr", 32'(ram_addr), 32'h12);
    step();
    mid();
    check("rd_c2_ram_en", 32'(ram_en), 32'd0);
    check("rd_c2_rvalid", 32'(p0_rvalid), 32'd0);
    step();
    mid();
    check("rd_c3_p0_rvalid", 32'(p0_rvalid), 32'd1);
    check("rd_c3_p0_rdata", 32'(p0_rdata), 32'hA5);
    check("rd_c3_p1_rvalid", 32'(p1_rvalid), 32'd0);
    step();
    mid();
    check("rd_c4_p0_rvalid", 32'(p0_rvalid), 32'd0);
    step();

    // Simultaneous: p0 writes 0x33 to 0x40, p1 reads 0x40.
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h40; p0_wdata = 8'h33;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h40;
    mid();
    check("sim_c0_p0_gnt", 32'(p0_gnt), 32'd1);
    check("sim_c0_p1_gnt", 32'(p1_gnt), 32'd0);
    step();
    p0_req = 1'b0;
    mid();
    check("sim_c1_p1_gnt", 32'(p1_gnt), 32'd1);
    check("sim_c1_ram_we", 32'(ram_we), 32'd1);
    check("sim_c1_ram_wdata", 32'(ram_wdata), 32'h33);
    step();
    p1_req = 1'b0;
    step();
    mid();
    check("sim_c3_wr_no_rvalid", 32'(p0_rvalid), 32'd0);
    step();
    mid();
    check("sim_c4_p1_rvalid", 32'(p1_rvalid), 32'd1);
    check("sim_c4_p1_rdata", 32'(p1_rdata), 32'h33);
    check("sim_c4_p0_rvalid", 32'(p0_rvalid), 32'd0);
    step();

    // Starvation: p0 hammers reads, p1 waits exactly four cycles.
    for (int i = 0; i < 10; i++) begin
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h00;
      p1_req = (i <= 4); p1_we = 1'b0; p1_addr = 8'h40;
      mid();
      check($sformatf("stv_c%0d_p0_gnt", i), 32'(p0_gnt), 32'(i != 4));
      check($sformatf("stv_c%0d_p1_gnt", i), 32'(p1_gnt), 32'(i == 4));
      step();
    end
    idle_ports();
    check("stv_cnt_cleared", 32'(dut.r_starve_cnt), 32'd0);
    for (int i = 0; i < 4; i++) step();

    // Pipelined reads 0x01..0x03.
    for (int c = 0; c < 7; c++) begin
      p0_req = (c < 3); p0_we = 1'b0; p0_addr = 8'(c + 1);
      mid();
      if (c >= 3 && c <= 5) begin
        check($sformatf("pipe_c%0d_rvalid", c), 32'(p0_rvalid), 32'd1);
        check($sformatf("pipe_c%0d_rdata", c), 32'(p0_rdata), 32'(8'h11 * (c - 2)));
      end
      if (c == 6) check("pipe_c6_rvalid", 32'(p0_rvalid), 32'd0);
      step();
    end

    // Enable gating with one read in flight.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h05; enable = 1'b1;
    mid();
    check("en_c0_gnt", 32'(p0_gnt), 32'd1);
    step();
    p0_addr = 8'h06; enable = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      mid();
      check($sformatf("en_c%0d_gnt", c), 32'({p0_gnt, p1_gnt}), 32'd0);
      if (c == 2) check("en_c2_ram_en", 32'(ram_en), 32'd0);
      if (c == 3) begin
        check("en_c3_rvalid", 32'(p0_rvalid), 32'd1);
        check("en_c3_rdata", 32'(p0_rdata), 32'h5A);
      end
      step();
    end
    enable = 1'b1;
    mid();
    check("en_c4_gnt", 32'(p0_gnt), 32'd1);
    check("en_c4_rvalid", 32'(p0_rvalid), 32'd0);
    step();
    p0_req = 1'b0;
    step();
    step();
    mid();
    check("en_c7_rvalid", 32'(p0_rvalid), 32'd1);
    check("en_c7_rdata", 32'(p0_rdata), 32'h66);
    step();

    // Reset one cycle after a p1 read grant.
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h12;
    mid();
    check("rr_c0_p1_gnt", 32'(p1_gnt), 32'd1);
    step();
    reset = 1'b0;
    #1;
    check("rr_ram_en", 32'(ram_en), 32'd0);
    check("rr_ram_addr", 32'(ram_addr), 32'd0);
    check("rr_p1_gnt", 32'(p1_gnt), 32'd0);
    check("rr_p0_rdata", 32'(p0_rdata), 32'd0);
    check("rr_p1_rdata", 32'(p1_rdata), 32'd0);
    p1_req = 1'b0;
    step();
    step();
    reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      mid();
      seen = seen | p0_rvalid | p1_rvalid;
      step();
    end
    check("rr_no_rvalid", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port data RAM between the control unit (port 0) and a secondary requester (port 1, debug/DMA loader). It grants at most one access per cycle. Port 0 has fixed priority, and a starvation counter bounds port 1's wait. Granted commands are registered onto the RAM bus, and read data is routed back to the owning port with a fixed latency.

## Interface
- ADDR_W, 8, RAM address width (matches `ram_addres_bus_size`)
- DATA_W, 8, RAM data width (matches `operand_size`)
- STARVE_LIMIT, 4, consecutive denied cycles after which port 1 wins priority; legal range 1..255
- clk  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  arbitration enable; low = no new grants, in-flight reads still complete
- p0_req / p1_req  in  1  access request, held until granted
- p0_we / p1_we  in  1  1 = write, 0 = read; stable while req high
- p0_addr / p1_addr  in  ADDR_W  address; stable while req high
- p0_wdata / p1_wdata  in  DATA_W  write data; stable while req high
- p0_gnt / p1_gnt  out  1  combinational accept this cycle
- p0_rdata / p1_rdata  out  DATA_W  registered read data
- p0_rvalid / p1_rvalid  out  1  one-cycle pulse, read data valid
- ram_en  out  1  registered RAM access strobe
- ram_we  out  1  registered write enable
- ram_addr  out  ADDR_W  registered address
- ram_wdata  out  DATA_W  registered write data
- ram_rdata  in  DATA_W  synchronous RAM read data, valid the cycle after ram_en

## Operation
- Grant rule, evaluated each cycle while enable=1 and reset=1:
  - If p1_req=1 and starve_cnt ≥ STARVE_LIMIT, grant port 1.
  - Otherwise, if p0_req=1, grant port 0.
  - Otherwise, if p1_req=1, grant port 1.
  - Otherwise, no grant.
- At most one of p0_gnt/p1_gnt is high in any cycle. Both gnts are forced 0 while enable=0 or reset=0.
- starve_cnt is an 8-bit counter:
  - Clears to 0 on a p1 grant, or when p1_req=0.
  - Increments, saturating at 255, when p1_req=1 and p1 is not granted (this includes cycles with enable=0).
- Command stage: on the edge ending a grant cycle, register ram_en=1 and the granted port's we/addr/wdata onto the RAM bus.
  - With no grant, ram_en=0 and ram_we=0. ram_addr and ram_wdata hold their previous values.
- Read tag pipeline: each granted read pushes a {valid, port} tag through two stages that track the RAM latency.
  - When the tag exits, ram_rdata is registered into the tagged port's rdata and that port's rvalid is pulsed.
  - The other port's rdata holds its previous value.
- Writes produce no rvalid.
- Back-to-back grants are allowed every cycle, and read and write traffic may interleave freely. Order is preserved because the pipeline is in-order.
- Same-address write followed by a read from either port returns the new data (RAM write-first). The arbiter adds no forwarding.

## Timing
- Reset value of every output is 0: p*_gnt, p*_rdata, p*_rvalid, ram_en, ram_we, ram_addr, ram_wdata. starve_cnt=0 and all tags are invalid.
- For a read granted in cycle N:
  - Cycle N+1: ram_en=1, ram_we=0, ram_addr=addr.
  - Cycle N+2: ram_rdata is valid.
  - Cycle N+3: pX_rdata updates and pX_rvalid=1 for exactly one cycle.
- For a write granted in cycle N: cycle N+1 has ram_en=1, ram_we=1. The write is complete at the end of N+1.
- Requester handshake: the transaction is consumed at the edge ending the cycle in which gnt=1. Deassert req or present the next transaction in the following cycle.
- Worst-case port 1 wait under continuous port 0 traffic is STARVE_LIMIT denied cycles, with the grant in the next cycle.
- enable falling mid-stream blocks new grants only. Already registered commands and pending reads complete, and rvalid still fires.
- Reset asserted mid-operation clears all state asynchronously. In-flight reads are discarded and no rvalid is produced after reset is released.

## Test plan
- Single read: preload RAM[0x12]=0xA5, p0 reads 0x12 → p0_gnt in cycle 0, ram_en/addr=0x12 in cycle 1, p0_rdata=0xA5 with p0_rvalid pulse in cycle 3, p1_rvalid stays 0.
- Simultaneous requests: p0 writes 0x33→0x40 while p1 requests a read at 0x40 in the same cycle → p0 granted first and p1 granted the next cycle; p1_rdata=0x33.
- Starvation, STARVE_LIMIT=4: p0_req held high for 10 cycles with p1_req high from cycle 0 → p1 denied in cycles 0–3 and granted in cycle 4; p0 granted in all other cycles; starve_cnt returns to 0.
- Pipelined reads: p0 reads 0x01, 0x02, 0x03 in back-to-back cycles, with RAM holding 0x11/0x22/0x33 → p0_rvalid high for 3 consecutive cycles with data 0x11, 0x22, 0x33.
- Enable gating: drop enable for 3 cycles with p0_req high and one read in flight → no gnt while enable=0, the in-flight rvalid still arrives, and the grant resumes the cycle enable returns.
- Reset mid-read: assert reset one cycle after a p1 read grant → all outputs are 0 immediately and no p1_rvalid appears after release.
